// File: rtl/trap_sequencer.sv
// -----------------------------------------------------------------------------
// trap_sequencer
//
// Sequences trap entry, MRET return and interrupt acceptance between the core
// pipeline and csr_unit. Each IDLE cycle it arbitrates among a synchronous
// exception, an MRET request and a pending interrupt (in that priority order),
// strobes trap_entry/trap_return into csr_unit for one cycle together with the
// registered trap_pc/trap_cause/trap_val, then redirects fetch to the captured
// handler vector or return address through a valid/ready handshake.
//
// Optional feature macro: TRAP_SEQ_IRQ_HOLDOFF_EN
//   Defined   : a 4-bit holdoff counter, loaded with IRQ_HOLDOFF on MRET and
//               decremented by boundary_valid pulses, blocks interrupts until it
//               reaches zero (guarantees forward progress after MRET).
//   Undefined : no counter; an interrupt may be taken on any IDLE boundary.
//               IRQ_HOLDOFF is then ignored.
//
// Parameters
//   IRQ_HOLDOFF    boundary pulses required after MRET before an interrupt (1-15)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   exc_req/cause/pc/val  synchronous exception request and its info
//   mret_req              MRET executing
//   irq_pending/cause     MIE-qualified interrupt request and cause
//   boundary_valid/pc     instruction boundary and next PC at that boundary
//   trap_vector           handler address from csr_unit (combinational on cause)
//   epc_in                saved mepc from csr_unit
//   trap_entry/return     one-cycle strobes to csr_unit
//   trap_pc/cause/val     registered trap info to csr_unit
//   flush                 one-cycle pipeline flush
//   redirect_valid/pc     redirect request to fetch (pc word aligned)
//   redirect_ready        fetch accepts the redirect
//   busy                  high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module trap_sequencer #(
    parameter int IRQ_HOLDOFF = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_req,
    input  logic [31:0] exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_val,
    input  logic        mret_req,
    input  logic        irq_pending,
    input  logic [31:0] irq_cause,
    input  logic        boundary_valid,
    input  logic [31:0] boundary_pc,
    input  logic [31:0] trap_vector,
    input  logic [31:0] epc_in,
    output logic        trap_entry,
    output logic        trap_return,
    output logic [31:0] trap_pc,
    output logic [31:0] trap_cause,
    output logic [31:0] trap_val,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        RETURN,
        REDIRECT
    } state_t;

    state_t state;
    state_t next_state;

    logic irq_allowed;
    logic take_exc;
    logic take_irq;

    // The two low bits of the redirect sources are dropped by word alignment.
    logic unused_low_bits;
    assign unused_low_bits = ^{trap_vector[1:0], epc_in[1:0]};

`ifdef TRAP_SEQ_IRQ_HOLDOFF_EN
    // Holdoff counter: loading on RETURN takes precedence over a boundary pulse
    // in that same cycle, so the full IRQ_HOLDOFF count is always served.
    logic [3:0] holdoff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdoff <= 4'd0;
        end else if (state == RETURN) begin
            holdoff <= 4'(IRQ_HOLDOFF);
        end else if (boundary_valid && (holdoff != 4'd0)) begin
            holdoff <= holdoff - 4'd1;
        end
    end

    assign irq_allowed = (holdoff == 4'd0);
`else
    logic unused_holdoff_param;
    assign unused_holdoff_param = (IRQ_HOLDOFF != 0);
    assign irq_allowed          = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and request arbitration. Requests are only looked at
    // in IDLE; in every other state the core is expected to stall on busy.
    always_comb begin
        next_state = state;
        take_exc   = 1'b0;
        take_irq   = 1'b0;
        case (state)
            IDLE: begin
                if (exc_req) begin
                    take_exc   = 1'b1;
                    next_state = ENTER;
                end else if (mret_req) begin
                    next_state = RETURN;
                end else if (irq_pending && boundary_valid && irq_allowed) begin
                    take_irq   = 1'b1;
                    next_state = ENTER;
                end
            end
            ENTER:    next_state = REDIRECT;
            RETURN:   next_state = REDIRECT;
            REDIRECT: begin
                if (redirect_ready) begin
                    next_state = IDLE;
                end
            end
            default:  next_state = IDLE;
        endcase
    end

    // Trap info is captured when an exception or interrupt is accepted and
    // otherwise held, so csr_unit sees it from the ENTER cycle onward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_pc    <= 32'd0;
            trap_cause <= 32'd0;
            trap_val   <= 32'd0;
        end else if (take_exc) begin
            trap_pc    <= exc_pc;
            trap_cause <= exc_cause;
            trap_val   <= exc_val;
        end else if (take_irq) begin
            trap_pc    <= boundary_pc;
            trap_cause <= irq_cause;
            trap_val   <= 32'd0;
        end
    end

    // The redirect target is captured during ENTER/RETURN because trap_vector
    // depends on the trap_cause register, which is only settled in ENTER.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc <= 32'd0;
        end else if (state == ENTER) begin
            redirect_pc <= {trap_vector[31:2], 2'b00};
        end else if (state == RETURN) begin
            redirect_pc <= {epc_in[31:2], 2'b00};
        end
    end

    // Strobes decode directly from the state register, so each lasts exactly
    // one cycle and all of them drop the moment reset is asserted.
    assign trap_entry     = (state == ENTER);
    assign trap_return    = (state == RETURN);
    assign flush          = (state == ENTER) || (state == RETURN);
    assign redirect_valid = (state == REDIRECT);
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_trap_sequencer
//
// Directed testbench for trap_sequencer: exception entry, interrupt entry,
// request priority, MRET with a stalled redirect, interrupt holdoff after MRET
// (expectation depends on TRAP_SEQ_IRQ_HOLDOFF_EN) and asynchronous reset in
// the middle of a redirect.
// -----------------------------------------------------------------------------
module tb_trap_sequencer;

    logic        clk;
    logic        rst_n;
    logic        exc_req;
    logic [31:0] exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_val;
    logic        mret_req;
    logic        irq_pending;
    logic [31:0] irq_cause;
    logic        boundary_valid;
    logic [31:0] boundary_pc;
    logic [31:0] trap_vector;
    logic [31:0] epc_in;
    logic        trap_entry;
    logic        trap_return;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_val;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;

    int errors = 0;
    int checks = 0;

    trap_sequencer #(
        .IRQ_HOLDOFF(2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exc_req        (exc_req),
        .exc_cause      (exc_cause),
        .exc_pc         (exc_pc),
        .exc_val        (exc_val),
        .mret_req       (mret_req),
        .irq_pending    (irq_pending),
        .irq_cause      (irq_cause),
        .boundary_valid (boundary_valid),
        .boundary_pc    (boundary_pc),
        .trap_vector    (trap_vector),
        .epc_in         (epc_in),
        .trap_entry     (trap_entry),
        .trap_return    (trap_return),
        .trap_pc        (trap_pc),
        .trap_cause     (trap_cause),
        .trap_val       (trap_val),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .busy           (busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where outputs are sampled
    // and the next inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the request/handshake bits for the next sampling edge.
    task automatic applyStimulus(input logic exc, input logic mret,
                                 input logic irq, input logic bnd,
                                 input logic rdy);
        exc_req        = exc;
        mret_req       = mret;
        irq_pending    = irq;
        boundary_valid = bnd;
        redirect_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed,
                            input logic expected);
        checkOutput(tag, {31'd0, observed}, {31'd0, expected});
    endtask

    // Check the five single-bit control outputs in one call.
    task automatic checkCtrl(input string tag, input logic entry, input logic ret,
                             input logic fl, input logic rv, input logic bsy);
        checkBit({tag, ".trap_entry"},     trap_entry,     entry);
        checkBit({tag, ".trap_return"},    trap_return,    ret);
        checkBit({tag, ".flush"},          flush,          fl);
        checkBit({tag, ".redirect_valid"}, redirect_valid, rv);
        checkBit({tag, ".busy"},           busy,           bsy);
    endtask

    initial begin
        rst_n       = 1'b0;
        exc_cause   = 32'd0;
        exc_pc      = 32'd0;
        exc_val     = 32'd0;
        irq_cause   = 32'd0;
        boundary_pc = 32'd0;
        trap_vector = 32'd0;
        epc_in      = 32'd0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- reset state ----------------
        tick();
        tick();
        checkCtrl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.redirect_pc", redirect_pc, 32'd0);
        checkOutput("reset.trap_pc",     trap_pc,     32'd0);
        checkOutput("reset.trap_cause",  trap_cause,  32'd0);
        checkOutput("reset.trap_val",    trap_val,    32'd0);
        rst_n = 1'b1;
        tick();
        checkCtrl("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- exception ----------------
        exc_cause   = 32'd2;
        exc_pc      = 32'h0000_0100;
        exc_val     = 32'hDEAD_BEEF;
        trap_vector = 32'h0000_0200;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkCtrl("exc.t1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("exc.trap_cause", trap_cause, 32'd2);
        checkOutput("exc.trap_pc",    trap_pc,    32'h0000_0100);
        checkOutput("exc.trap_val",   trap_val,   32'hDEAD_BEEF);
        tick();
        checkCtrl("exc.t2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("exc.redirect_pc", redirect_pc, 32'h0000_0200);
        tick();
        checkCtrl("exc.t3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- interrupt without boundary is ignored ----------------
        irq_cause   = 32'h8000_000B;
        boundary_pc = 32'h0000_0044;
        trap_vector = 32'h0000_0307;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checkCtrl("irq_noboundary", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("irq_noboundary.trap_cause", trap_cause, 32'd2);

        // ---------------- interrupt ----------------
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkCtrl("irq.t1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("irq.trap_pc",    trap_pc,    32'h0000_0044);
        checkOutput("irq.trap_cause", trap_cause, 32'h8000_000B);
        checkOutput("irq.trap_val",   trap_val,   32'd0);
        tick();
        checkCtrl("irq.t2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("irq.redirect_pc", redirect_pc, 32'h0000_0304);
        tick();
        checkCtrl("irq.t3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- simultaneous requests: exception wins ----------------
        exc_cause   = 32'd5;
        exc_pc      = 32'h0000_0208;
        exc_val     = 32'h0000_0011;
        boundary_pc = 32'h0000_0500;
        trap_vector = 32'h0000_0200;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkCtrl("prio.t1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("prio.trap_cause", trap_cause, 32'd5);
        checkOutput("prio.trap_pc",    trap_pc,    32'h0000_0208);
        checkOutput("prio.trap_val",   trap_val,   32'h0000_0011);
        tick();
        checkCtrl("prio.t2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkCtrl("prio.t3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- MRET with stalled redirect ----------------
        epc_in = 32'h0000_0103;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCtrl("mret.t1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("mret.trap_cause_held", trap_cause, 32'd5);
        checkOutput("mret.trap_pc_held",    trap_pc,    32'h0000_0208);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkCtrl("mret.stall", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            checkOutput("mret.redirect_pc", redirect_pc, 32'h0000_0100);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkCtrl("mret.done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- interrupt right after MRET ----------------
        irq_cause   = 32'h8000_0007;
        boundary_pc = 32'h0000_0060;
        trap_vector = 32'h0000_0400;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
`ifdef TRAP_SEQ_IRQ_HOLDOFF_EN
        tick();
        checkCtrl("holdoff.b1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkCtrl("holdoff.b2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkCtrl("holdoff.take", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("holdoff.trap_pc",    trap_pc,    32'h0000_0060);
        checkOutput("holdoff.trap_cause", trap_cause, 32'h8000_0007);
        tick();
        checkOutput("holdoff.redirect_pc", redirect_pc, 32'h0000_0400);
        tick();
        checkCtrl("holdoff.done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- asynchronous reset during REDIRECT ----------------
        exc_cause   = 32'd4;
        exc_pc      = 32'h0000_0700;
        exc_val     = 32'h0000_0123;
        trap_vector = 32'h0000_0800;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkCtrl("rstmid.before", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("rstmid.before.redirect_pc", redirect_pc, 32'h0000_0800);
        #2;
        rst_n = 1'b0;
        #1;
        checkCtrl("rstmid.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rstmid.redirect_pc", redirect_pc, 32'd0);
        checkOutput("rstmid.trap_pc",     trap_pc,     32'd0);
        checkOutput("rstmid.trap_cause",  trap_cause,  32'd0);
        checkOutput("rstmid.trap_val",    trap_val,    32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkCtrl("rstmid.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Sequences trap entry, MRET return and interrupt acceptance between the core pipeline and `csr_unit`. It arbitrates each cycle among a synchronous exception, an MRET request and a pending interrupt. It drives the one-cycle `trap_entry`/`trap_return` strobes and the registered `trap_pc`/`trap_cause`/`trap_val` into `csr_unit`. It then redirects the fetch unit to the captured handler vector or return address through a valid/ready handshake.

## Interface
Parameters:
- `IRQ_HOLDOFF`, default 1: number of `boundary_valid` pulses required after an MRET before an interrupt may be taken. Used only with `TRAP_SEQ_IRQ_HOLDOFF_EN`. Range 1–15.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `exc_req`  in  1  synchronous exception from the executing instruction.
- `exc_cause`  in  32  exception cause; bit 31 = 0.
- `exc_pc`  in  32  PC of the faulting instruction.
- `exc_val`  in  32  bad address or instruction.
- `mret_req`  in  1  MRET is executing.
- `irq_pending`  in  1  from `csr_unit.interrupt_pending`; already qualified by MIE.
- `irq_cause`  in  32  from `csr_unit.interrupt_cause`.
- `boundary_valid`  in  1  an instruction boundary; interrupt may be taken here.
- `boundary_pc`  in  32  PC of the next instruction at that boundary.
- `trap_vector`  in  32  from `csr_unit`; combinational on `trap_cause`.
- `epc_in`  in  32  from `csr_unit.epc_out`.
- `trap_entry`  out  1  one-cycle strobe to `csr_unit`.
- `trap_return`  out  1  one-cycle strobe to `csr_unit`.
- `trap_pc`, `trap_cause`, `trap_val`  out  32 each  registered trap info to `csr_unit`.
- `flush`  out  1  one-cycle pipeline flush.
- `redirect_valid`  out  1  redirect request to fetch.
- `redirect_pc`  out  32  redirect target; bits [1:0] forced to 0.
- `redirect_ready`  in  1  fetch accepts the redirect.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The state register has four states: IDLE, ENTER, RETURN, REDIRECT.
- Request inputs are sampled only in IDLE. In any other state they are ignored; the core must stall on `busy`.
- Priority in IDLE:
  - `exc_req` wins over `mret_req`.
  - `mret_req` wins over an interrupt.
  - An interrupt is taken only when `irq_pending && boundary_valid` and the holdoff has expired.
- IDLE with exception → ENTER. Latch `trap_pc=exc_pc`, `trap_cause=exc_cause`, `trap_val=exc_val`.
- IDLE with interrupt → ENTER. Latch `trap_pc=boundary_pc`, `trap_cause=irq_cause`, `trap_val=0`.
- IDLE with `mret_req` → RETURN. Trap info registers are unchanged.
- ENTER, one cycle:
  - `trap_entry=1`, `flush=1`.
  - Capture `redirect_pc={trap_vector[31:2],2'b00}`.
  - Next state REDIRECT.
- RETURN, one cycle:
  - `trap_return=1`, `flush=1`.
  - Capture `redirect_pc={epc_in[31:2],2'b00}`. mepc is not modified by MRET.
  - Load the holdoff counter with `IRQ_HOLDOFF`.
  - Next state REDIRECT.
- REDIRECT:
  - `redirect_valid=1`; `redirect_pc` is stable.
  - On `redirect_ready` → IDLE. Otherwise stay, holding all outputs.
- Holdoff counter (4 bits):
  - Decrements on each `boundary_valid` pulse while nonzero, in any state.
  - Saturates at 0.
  - An interrupt is allowed only when the counter is 0.
- `trap_pc`/`trap_cause`/`trap_val` hold their last values until the next capture.

## Timing
- Exception or interrupt sampled in IDLE at cycle T:
  - `trap_entry` and `flush` high at T+1.
  - Trap info valid from T+1.
  - `redirect_valid` high from T+2.
- MRET sampled at T: `trap_return` and `flush` high at T+1; `redirect_valid` high from T+2.
- Minimum request-to-request spacing is 3 cycles (T, T+1, T+2 with ready already high); the next request is sampled at T+3.
- `trap_entry`, `trap_return` and `flush` are never high for two consecutive cycles.
- `trap_entry` and `trap_return` are never high in the same cycle.
- Reset values:
  - State IDLE.
  - All outputs 0, including `busy`, `redirect_pc` and the trap info registers.
  - Holdoff counter 0.
- Reset asserted mid-sequence forces IDLE immediately; no strobe is emitted after reset release.
- `irq_pending` without `boundary_valid` is ignored; nothing is queued.

## Configuration
- Macro `TRAP_SEQ_IRQ_HOLDOFF_EN`.
- Defined: the holdoff counter is implemented as described, which guarantees forward progress of at least `IRQ_HOLDOFF` instructions after MRET.
- Undefined: no counter is built. Interrupts are allowed in any IDLE cycle with `boundary_valid`, including the cycle right after returning to IDLE. `IRQ_HOLDOFF` is ignored.

## Test plan
- Exception: `exc_req` with cause 2, pc 0x100, val 0xDEADBEEF, `trap_vector`=0x200 → T+1 shows `trap_entry`, `flush`, and `trap_cause`=2 / `trap_pc`=0x100 / `trap_val`=0xDEADBEEF; T+2 shows `redirect_valid` with `redirect_pc`=0x200.
- Interrupt: `irq_pending`, `boundary_valid`, `boundary_pc`=0x44, `irq_cause`=0x8000000B → `trap_pc`=0x44, `trap_val`=0, `trap_entry` at T+1.
- Simultaneous `exc_req`, `mret_req` and interrupt → only the exception is taken; no `trap_return`.
- MRET with `epc_in`=0x103 → `trap_return` at T+1; `redirect_pc`=0x100; `redirect_ready` held low 3 cycles → `redirect_valid` and `busy` hold for those cycles.
- Holdoff (macro defined, `IRQ_HOLDOFF`=2): MRET, then `irq_pending` held high → no `trap_entry` until the 2nd `boundary_valid` has passed. With the macro undefined, the interrupt is taken on the first IDLE boundary.
- `rst_n` low during REDIRECT → all outputs 0 asynchronously; after release, no strobe occurs without a new request.
